// File: rtl/lcd_write_ctrl.sv
// HD44780-style LCD write controller: power-up delay, fixed four-byte init
// sequence, then single-byte writes with tick-timed setup/enable/hold/exec phases.
module lcd_write_ctrl #(
  parameter int unsigned SETUP_TICKS  = 1,
  parameter int unsigned E_HIGH_TICKS = 1,
  parameter int unsigned HOLD_TICKS   = 1,
  parameter int unsigned EXEC_TICKS   = 10,
  parameter int unsigned CLR_TICKS    = 400,
  parameter int unsigned PWRUP_TICKS  = 4000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       tick,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam int unsigned Max0 = (SETUP_TICKS > E_HIGH_TICKS) ? SETUP_TICKS : E_HIGH_TICKS;
  localparam int unsigned Max1 = (HOLD_TICKS > EXEC_TICKS) ? HOLD_TICKS : EXEC_TICKS;
  localparam int unsigned Max2 = (CLR_TICKS > PWRUP_TICKS) ? CLR_TICKS : PWRUP_TICKS;
  localparam int unsigned Max3 = (Max0 > Max1) ? Max0 : Max1;
  localparam int unsigned Max4 = (Max3 > Max2) ? Max3 : Max2;
  localparam int unsigned MaxTicks = (Max4 > 1) ? Max4 : 1;
  localparam int unsigned CntW = $clog2(MaxTicks + 1);

  localparam logic [CntW:0] LimSetup = (CntW + 1)'(SETUP_TICKS);
  localparam logic [CntW:0] LimEhigh = (CntW + 1)'(E_HIGH_TICKS);
  localparam logic [CntW:0] LimHold  = (CntW + 1)'(HOLD_TICKS);
  localparam logic [CntW:0] LimExec  = (CntW + 1)'(EXEC_TICKS);
  localparam logic [CntW:0] LimClr   = (CntW + 1)'(CLR_TICKS);
  localparam logic [CntW:0] LimPwrup = (CntW + 1)'(PWRUP_TICKS);

  // Encoding 3'd7 is unused and recovers to StPwrup.
  typedef enum logic [2:0] {
    StPwrup = 3'd0,
    StLoad  = 3'd1,
    StSetup = 3'd2,
    StEhigh = 3'd3,
    StHold  = 3'd4,
    StExec  = 3'd5,
    StIdle  = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            done_q, done_d;
  logic            e_q;

  logic [CntW:0]   cnt_inc;
  logic [CntW:0]   lim;
  logic            timed;
  logic            tick_done;
  logic            is_clr;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  assign wr_ready  = (state_q == StIdle) && done_q;
  assign init_done = done_q;
  assign lcd_rs    = rs_q;
  assign lcd_data  = data_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = e_q;

  // Clear and home need the long execution wait.
  assign is_clr = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));

  // Next-state, tick counting and latching of the byte being written.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rs_d    = rs_q;
    data_d  = data_q;
    done_d  = done_q;
    cnt_inc = {1'b0, cnt_q} + 1'b1;
    timed   = 1'b0;
    lim     = '0;

    case (state_q)
      StPwrup: begin timed = 1'b1; lim = LimPwrup; end
      StSetup: begin timed = 1'b1; lim = LimSetup; end
      StEhigh: begin timed = 1'b1; lim = LimEhigh; end
      StHold:  begin timed = 1'b1; lim = LimHold;  end
      StExec:  begin timed = 1'b1; lim = is_clr ? LimClr : LimExec; end
      default: begin timed = 1'b0; lim = '0; end
    endcase

    tick_done = timed && tick && (cnt_inc >= lim);
    // Counter restarts at zero whenever a timed state is left, so the next one starts clean.
    if (timed && tick) begin
      cnt_d = tick_done ? '0 : cnt_inc[CntW-1:0];
    end

    case (state_q)
      StPwrup: if (tick_done) state_d = StLoad;
      StLoad: begin
        rs_d    = 1'b0;
        data_d  = init_byte(idx_q[1:0]);
        idx_d   = idx_q + 3'd1;
        cnt_d   = '0;
        state_d = StSetup;
      end
      StSetup: if (tick_done) state_d = StEhigh;
      StEhigh: if (tick_done) state_d = StHold;
      StHold:  if (tick_done) state_d = StExec;
      StExec: begin
        if (tick_done) begin
          if (done_q) begin
            state_d = StIdle;
          end else if (idx_q == 3'd4) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StIdle: begin
        // A tick coinciding with the transfer is dropped: SETUP starts from zero.
        if (wr_valid && wr_ready) begin
          rs_d    = wr_rs;
          data_d  = wr_data;
          cnt_d   = '0;
          state_d = StSetup;
        end
      end
      default: begin
        state_d = StPwrup;
        cnt_d   = '0;
        idx_d   = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears the bus and drops E immediately.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= StPwrup;
      cnt_q   <= '0;
      idx_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      done_q  <= done_d;
      e_q     <= (state_d == StEhigh);
    end
  end

endmodule

// File: doc/lcd_write_ctrl.md
LCD_WRITE_CTRL -- requirements
Module: lcd_write_ctrl

Interface
REQ-001 Parameter SETUP_TICKS, default 1: ticks that RS and DATA are held stable before E rises.
REQ-002 Parameter E_HIGH_TICKS, default 1: ticks that E stays high.
REQ-003 Parameter HOLD_TICKS, default 1: ticks that RS and DATA are held after E falls.
REQ-004 Parameter EXEC_TICKS, default 10: ticks to wait for a normal command or data write to execute.
REQ-005 Parameter CLR_TICKS, default 400: ticks to wait after a clear or home command (RS=0, byte 0x01 or 0x02).
REQ-006 Parameter PWRUP_TICKS, default 4000: ticks to wait after reset before the first init command.
REQ-007 Port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 Port rst, input, 1 bit: reset; asynchronous, active-low.
REQ-009 Port tick, input, 1 bit: one-cycle timing strobe from the upstream timer.
REQ-010 Port wr_valid, input, 1 bit: a write request is present.
REQ-011 Port wr_rs, input, 1 bit: 0 = command, 1 = character data.
REQ-012 Port wr_data, input, 8 bits: the byte to write.
REQ-013 Port wr_ready, output, 1 bit: the block can accept a write.
REQ-014 Port init_done, output, 1 bit: the power-up init sequence is complete.
REQ-015 Port lcd_rs, output, 1 bit: LCD register select.
REQ-016 Port lcd_rw, output, 1 bit: LCD read/write; tied to 0.
REQ-017 Port lcd_e, output, 1 bit: LCD enable strobe.
REQ-018 Port lcd_data, output, 8 bits: LCD data bus.

Function
REQ-019 States: PWRUP, LOAD, SETUP, EHIGH, HOLD, EXEC, IDLE.
REQ-020 Timed-state counting:
- The tick counter clears on entry to every timed state (PWRUP, SETUP, EHIGH, HOLD, EXEC).
- Only cycles with tick=1 are counted.
- The state exits on the clock edge of the tick that makes the count equal to its parameter.
- Ticks that arrive in IDLE or LOAD are ignored.
REQ-021 Power-up and init:
- PWRUP exits to LOAD after PWRUP_TICKS ticks.
- LOAD fetches the next init byte, always with rs=0, in order 0x38, 0x0C, 0x01, 0x06; LOAD lasts one cycle and then goes to SETUP.
REQ-022 Write sequencing: SETUP -> EHIGH -> HOLD -> EXEC, each lasting its own parameter's tick count.
REQ-023 EXEC wait length: CLR_TICKS when the latched rs=0 and the latched byte is 0x01 or 0x02; otherwise EXEC_TICKS.
REQ-024 After EXEC:
- If init bytes remain, go to LOAD.
- After the fourth init byte, set init_done=1, which then stays 1 until reset, and go to IDLE.
- After a user write, go to IDLE.
REQ-025 wr_ready = 1 only when the state is IDLE and init_done=1 (combinational from state).
REQ-026 Handshake:
- A transfer happens on a clock edge with wr_valid=1 and wr_ready=1.
- On that edge, latch wr_rs and wr_data and go directly to SETUP.
- wr_ready falls in the next cycle.
REQ-027 When wr_ready=0, wr_valid, wr_rs and wr_data are ignored; the requester holds them until the transfer.
REQ-028 lcd_rs and lcd_data come from registers holding the latched values and stay constant from SETUP entry through HOLD exit.
REQ-029 lcd_e = 1 only while the state is EHIGH.
REQ-030 Back-to-back writes: if wr_valid=1 in the first IDLE cycle after EXEC, the transfer happens in that cycle (at most 1 idle cycle between writes).
REQ-031 A tick arriving in the same cycle as a transfer is not counted toward SETUP.
REQ-032 An unreachable state encoding returns to PWRUP on the next clock.

Reset
REQ-033 While rst=0, regardless of clock:
- state=PWRUP, counters=0, init index=0;
- init_done=0, wr_ready=0;
- lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00.
REQ-034 Reset asserted mid-write immediately drops lcd_e and aborts the transfer. After release, the full init sequence repeats; no pending write is retained.

Verification
REQ-035 Release reset with tick every 4 cycles and default parameters:
- lcd_e pulses exactly 4 times;
- lcd_data reads 0x38, 0x0C, 0x01, 0x06 at those pulses;
- the wait after 0x01 is 400 ticks;
- init_done rises after the 0x06 EXEC.
REQ-036 After init, write rs=1, data=0x41:
- lcd_rs=1 and lcd_data=0x41 are stable for 1 tick before lcd_e rises;
- lcd_e is high for exactly 1 tick;
- the values hold for 1 tick after lcd_e falls;
- wr_ready returns after 10 EXEC ticks.
REQ-037 Hold wr_valid=1 continuously with bytes 0x48 then 0x49: exactly two E pulses, separated by SETUP+EHIGH+HOLD+EXEC ticks plus at most 1 cycle.
REQ-038 Write rs=0, data=0x02: EXEC lasts 400 ticks; the same write with rs=1 lasts 10 ticks.
REQ-039 Drive tick=0 during SETUP for 50 cycles: the state and outputs freeze and lcd_e stays 0.
REQ-040 Assert rst during EHIGH:
- lcd_e=0 with no clock edge needed;
- after release, PWRUP repeats and the first lcd_data on an E pulse is 0x38.
